rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: NREGS, 8, number of architectural 16-bit registers.
REQ-002 Parameter: DW, 16, register data width.
REQ-003 Parameter: AW, 3, register address width (log2 NREGS).
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: req0_valid  input  1  ALU write-back request.
REQ-007 Port: req0_addr  input  AW  ALU destination register.
REQ-008 Port: req0_data  input  DW  ALU result.
REQ-009 Port: req0_ready  output  1  ALU request accepted this cycle.
REQ-010 Port: req1_valid / req1_addr / req1_data / req1_ready  same widths  load-unit write-back request.
REQ-011 Port: rsv_valid  input  1  decode reserves a destination register.
REQ-012 Port: rsv_addr  input  AW  register being reserved.
REQ-013 Port: qa_addr, qb_addr  input  AW each  decode source-operand addresses.
REQ-014 Port: hazard  output  1  a source operand is pending write-back.
REQ-015 Port: rf_we  output  NREGS  one-hot write enables to the per-register 16-bit register instances.
REQ-016 Port: rf_din  output  DW  shared write data to all register instances.
REQ-017 Port: busy  output  NREGS  scoreboard, bit i set = register i awaiting write-back.
REQ-018 Port: wb_count  output  16  completed write-back count.

Function
REQ-019 At most one request SHALL be accepted per cycle; reqN_ready high only in a cycle where reqN_valid is high and requester N is granted (combinational from valid and priority state).
REQ-020 Only one valid: that requester SHALL be granted.
REQ-021 Both valid: grant SHALL go to the requester not granted most recently (round-robin); priority pointer updates only on an accepted handshake.
REQ-022 Requester rule: once valid is high, addr/data stay stable until ready; the block SHALL NOT buffer more than the one accepted request.
REQ-023 Accepted request at edge N: rf_we SHALL be one-hot at bit addr and rf_din SHALL equal data during cycle N+1 (latency 1, registered); rf_we all-zero in any cycle following no acceptance.
REQ-024 rf_din SHALL hold its last value when no request is accepted.
REQ-025 Address 0 is hardwired zero: request to addr 0 SHALL handshake normally, rf_we stays all-zero, busy unchanged, wb_count increments.
REQ-026 rsv_valid with rsv_addr != 0 SHALL set busy[rsv_addr] at the next edge; rsv_addr 0 ignored.
REQ-027 An accepted write-back to addr k SHALL clear busy[k] at the same edge the write is registered.
REQ-028 Same-edge reservation and write-back to the same k: set SHALL win (busy[k] stays 1).
REQ-029 hazard = busy[qa_addr] | busy[qb_addr], combinational from current busy.
REQ-030 Write-back to a non-busy register SHALL still be performed (no error flag).
REQ-031 wb_count SHALL increment by 1 per accepted handshake, wrapping 16'hFFFF -> 0.

Reset
REQ-032 While rst high: rf_we = 0, rf_din = 0, busy = 0, wb_count = 0, priority pointer selects req0 first; ready outputs low.
REQ-033 rst asserted mid-transaction SHALL discard any accepted-but-unwritten request (no rf_we pulse after rst release) and clear all reservations.
REQ-034 First edge after rst deassertion SHALL accept requests normally.

Verification
REQ-035 After reset, req0 valid addr 3 data 16'hBEEF -> req0_ready high same cycle; next cycle rf_we = 8'b0000_1000, rf_din = 16'hBEEF; wb_count = 1.
REQ-036 req0 and req1 both valid for 4 cycles (addr 1, addr 2) -> grants alternate 0,1,0,1; req1 granted first if prior grant was req0.
REQ-037 rsv addr 5, then qa_addr 5 -> hazard 1; req1 writes addr 5 -> busy[5] clears, hazard 0 next cycle.
REQ-038 Same cycle rsv addr 4 and accepted write addr 4 with busy[4]=1 -> busy[4] remains 1.
REQ-039 Request to addr 0 data 16'h1234 -> ready high, rf_we stays 0, wb_count increments; wb_count preset by 65535 writes then one more -> 0.
REQ-040 rst pulsed in cycle between acceptance and write -> rf_we never pulses, busy = 0, wb_count = 0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - write-back request, reservation and register-file bus
// The slave side is the arbiter; the master side is the pipeline (or bench) around it.
interface rf_wb_arbiter_if #(
  parameter int NREGS = 8,
  parameter int DW    = 16,
  parameter int AW    = 3
);
  logic             req0_valid;
  logic [AW-1:0]    req0_addr;
  logic [DW-1:0]    req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [AW-1:0]    req1_addr;
  logic [DW-1:0]    req1_data;
  logic             req1_ready;
  logic             rsv_valid;
  logic [AW-1:0]    rsv_addr;
  logic [AW-1:0]    qa_addr;
  logic [AW-1:0]    qb_addr;
  logic             hazard;
  logic [NREGS-1:0] rf_we;
  logic [DW-1:0]    rf_din;
  logic [NREGS-1:0] busy;
  logic [15:0]      wb_count;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  rsv_valid, rsv_addr, qa_addr, qb_addr,
    output hazard, rf_we, rf_din, busy, wb_count
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output rsv_valid, rsv_addr, qa_addr, qb_addr,
    input  hazard, rf_we, rf_din, busy, wb_count
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-requester round-robin register-file write-back arbiter
// with a destination-register scoreboard; register 0 is hardwired zero.
module rf_wb_arbiter #(
  parameter int NREGS = 8,
  parameter int DW    = 16,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_arbiter_if.slave    wb
);

  logic             r_prio;
  logic [NREGS-1:0] r_rf_we;
  logic [DW-1:0]    r_rf_din;
  logic [NREGS-1:0] r_busy;
  logic [15:0]      r_wb_count;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_accept;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;
  logic [NREGS-1:0] w_addr_oh;
  logic [NREGS-1:0] w_rsv_oh;
  logic [NREGS-1:0] w_busy_nxt;

  // r_prio set means req1 wins a tie; grants are suppressed while in reset
  always_comb begin
    w_gnt0   = ~rst & wb.req0_valid & (~wb.req1_valid | ~r_prio);
    w_gnt1   = ~rst & wb.req1_valid & (~wb.req0_valid |  r_prio);
    w_accept = w_gnt0 | w_gnt1;
    w_addr   = w_gnt1 ? wb.req1_addr : wb.req0_addr;
    w_data   = w_gnt1 ? wb.req1_data : wb.req0_data;
  end

  always_comb begin
    w_addr_oh = '0;
    w_rsv_oh  = '0;
    if (w_accept && (w_addr != '0)) begin
      w_addr_oh[w_addr] = 1'b1;
    end
    if (wb.rsv_valid && (wb.rsv_addr != '0)) begin
      w_rsv_oh[wb.rsv_addr] = 1'b1;
    end
    // a reservation landing on the same edge as the write-back keeps the register busy
    w_busy_nxt = (r_busy & ~w_addr_oh) | w_rsv_oh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio     <= 1'b0;
      r_rf_we    <= '0;
      r_rf_din   <= '0;
      r_busy     <= '0;
      r_wb_count <= '0;
    end else begin
      r_rf_we <= w_addr_oh;
      r_busy  <= w_busy_nxt;
      if (w_accept) begin
        r_rf_din   <= w_data;
        r_wb_count <= r_wb_count + 16'd1;
        r_prio     <= w_gnt0;
      end
    end
  end

  assign wb.req0_ready = w_gnt0;
  assign wb.req1_ready = w_gnt1;
  assign wb.hazard     = r_busy[wb.qa_addr] | r_busy[wb.qb_addr];
  assign wb.rf_we      = r_rf_we;
  assign wb.rf_din     = r_rf_din;
  assign wb.busy       = r_busy;
  assign wb.wb_count   = r_wb_count;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed and randomized bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  localparam int NREGS = 8;
  localparam int DW    = 16;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rf_wb_arbiter_if #(.NREGS(NREGS), .DW(DW), .AW(AW)) bus ();

  rf_wb_arbiter #(.NREGS(NREGS), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit          m_busy [NREGS];
  int          m_count;
  int          m_last;
  int          m_we_addr;
  logic [15:0] m_din;

  logic        s_v0, s_v1, s_rv;
  logic [2:0]  s_a0, s_a1, s_ra, s_qa, s_qb;
  logic [15:0] s_d0, s_d1;
  logic        o_r0, o_r1;
  bit          p0, p1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] busy_vec();
    logic [7:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [7:0] we_vec();
    logic [7:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = (m_we_addr != 0) && (i == m_we_addr);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    m_count   = 0;
    m_last    = 1;
    m_we_addr = 0;
    m_din     = '0;
  endtask

  task automatic idle();
    s_v0 = 0; s_v1 = 0; s_rv = 0;
    s_a0 = 0; s_a1 = 0; s_ra = 0; s_qa = 0; s_qb = 0;
    s_d0 = 0; s_d1 = 0;
  endtask

  task automatic drive();
    bus.req0_valid = s_v0; bus.req0_addr = s_a0; bus.req0_data = s_d0;
    bus.req1_valid = s_v1; bus.req1_addr = s_a1; bus.req1_data = s_d1;
    bus.rsv_valid  = s_rv; bus.rsv_addr  = s_ra;
    bus.qa_addr    = s_qa; bus.qb_addr   = s_qb;
  endtask

  task automatic step(input string tag);
    int          g;
    int          addr;
    logic [15:0] data;
    @(negedge clk);
    drive();
    #1;
    if (s_v0 && s_v1) g = (m_last == 0) ? 1 : 0;
    else if (s_v0)    g = 0;
    else if (s_v1)    g = 1;
    else              g = -1;
    o_r0 = bus.req0_ready;
    o_r1 = bus.req1_ready;
    chk({tag, ".ready0"}, 32'(o_r0), 32'(g == 0));
    chk({tag, ".ready1"}, 32'(o_r1), 32'(g == 1));
    chk({tag, ".hazard"}, 32'(bus.hazard), 32'(m_busy[s_qa] || m_busy[s_qb]));
    if (g >= 0) begin
      addr      = (g == 0) ? int'(s_a0) : int'(s_a1);
      data      = (g == 0) ? s_d0 : s_d1;
      m_count   = (m_count + 1) % 65536;
      m_last    = g;
      m_din     = data;
      m_we_addr = addr;
      if (addr != 0) m_busy[addr] = 1'b0;
    end else begin
      m_we_addr = 0;
    end
    if (s_rv && s_ra != 0) m_busy[s_ra] = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".rf_we"},    32'(bus.rf_we),    32'(we_vec()));
    chk({tag, ".rf_din"},   32'(bus.rf_din),   32'(m_din));
    chk({tag, ".busy"},     32'(bus.busy),     32'(busy_vec()));
    chk({tag, ".wb_count"}, 32'(bus.wb_count), 32'(m_count));
  endtask

  initial begin
    idle();
    drive();
    model_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 3'd3;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.ready0",   32'(bus.req0_ready), 32'(0));
    chk("rst.rf_we",    32'(bus.rf_we),      32'(0));
    chk("rst.rf_din",   32'(bus.rf_din),     32'(0));
    chk("rst.busy",     32'(bus.busy),       32'(0));
    chk("rst.wb_count", 32'(bus.wb_count),   32'(0));
    rst = 1'b0;
    idle();
    drive();

    // first request after reset
    s_v0 = 1; s_a0 = 3'd3; s_d0 = 16'hBEEF;
    step("first");
    chk("first.we_const", 32'(bus.rf_we), 32'h08);
    chk("first.din_const", 32'(bus.rf_din), 32'hBEEF);

    // round robin with both requesters valid; req0 was granted last
    idle();
    s_v0 = 1; s_a0 = 3'd1; s_d0 = 16'h1111;
    s_v1 = 1; s_a1 = 3'd2; s_d1 = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      step("rr");
      chk("rr.grant1", 32'(o_r1), 32'(k % 2 == 0));
    end

    // reservation and hazard clearing
    idle(); s_rv = 1; s_ra = 3'd5;
    step("rsv5");
    idle(); s_qa = 3'd5;
    step("haz5");
    chk("haz5.const", 32'(bus.hazard), 32'(1));
    idle(); s_qa = 3'd5; s_v1 = 1; s_a1 = 3'd5; s_d1 = 16'h5555;
    step("wb5");
    idle(); s_qa = 3'd5;
    step("clr5");
    chk("clr5.const", 32'(bus.hazard), 32'(0));

    // reservation wins over a same-edge write-back
    idle(); s_rv = 1; s_ra = 3'd4;
    step("rsv4");
    idle(); s_rv = 1; s_ra = 3'd4; s_v0 = 1; s_a0 = 3'd4; s_d0 = 16'h4444;
    step("setwins");
    chk("setwins.busy4", 32'(bus.busy[4]), 32'(1));

    // address zero handshakes but never writes
    idle(); s_v0 = 1; s_a0 = 3'd0; s_d0 = 16'h1234;
    step("addr0");
    chk("addr0.we_const", 32'(bus.rf_we), 32'(0));

    // randomized traffic against the reference model
    idle(); p0 = 0; p1 = 0;
    for (int n = 0; n < 400; n++) begin
      if (!p0) begin s_v0 = 1'($urandom_range(0, 1)); s_a0 = 3'($urandom); s_d0 = 16'($urandom); end
      if (!p1) begin s_v1 = 1'($urandom_range(0, 1)); s_a1 = 3'($urandom); s_d1 = 16'($urandom); end
      s_rv = 1'($urandom_range(0, 1));
      s_ra = 3'($urandom);
      s_qa = 3'($urandom);
      s_qb = 3'($urandom);
      step("rand");
      p0 = s_v0 && !o_r0;
      p1 = s_v1 && !o_r1;
    end

    // reset between handshake and write discards the request and reservations
    idle(); s_rv = 1; s_ra = 3'd2;
    step("prersv");
    idle(); s_v0 = 1; s_a0 = 3'd6; s_d0 = 16'h6666;
    @(negedge clk);
    drive();
    #1;
    chk("midrst.ready_before", 32'(bus.req0_ready), 32'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("midrst.ready_in_rst", 32'(bus.req0_ready), 32'(0));
    @(posedge clk);
    #1;
    chk("midrst.rf_we",    32'(bus.rf_we),    32'(0));
    chk("midrst.busy",     32'(bus.busy),     32'(0));
    chk("midrst.wb_count", 32'(bus.wb_count), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle();
    drive();
    step("postrst.idle");
    idle(); s_v1 = 1; s_a1 = 3'd7; s_d1 = 16'h7777;
    step("postrst.accept");

    // wb_count wrap after 65535 further handshakes
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    idle(); s_v0 = 1; s_a0 = 3'd0; s_d0 = 16'hA5A5;
    drive();
    repeat (65535) @(posedge clk);
    #1;
    m_count = 65535; m_last = 0; m_din = 16'hA5A5; m_we_addr = 0;
    chk("wrap.ffff", 32'(bus.wb_count), 32'hFFFF);
    step("wrap");
    chk("wrap.zero", 32'(bus.wb_count), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
